// File: rtl/wb_master_bridge_pkg.sv
// Shared types and constants for the picorv32-to-Wishbone bridge.
package wb_master_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned ERR_W  = 2;

    // Bit positions inside err_status.
    localparam int unsigned ERR_BUS = 0;
    localparam int unsigned ERR_TO  = 1;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CYCLE = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Latched Wishbone request, held stable for the whole cycle.
    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
        logic              we;
        logic [SEL_W-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_master_bridge_timer.sv
// Saturating watchdog counter; expired flags the last permitted CYCLE clock.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock_main,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over count; counting stops at CNT_MAX so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock_main) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timer
            assign expired = 1'b0;
        end else begin : g_timer
            assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_master_bridge.sv
// Converts one windowed picorv32 memory request into one Wishbone classic cycle,
// with watchdog, bus-error capture and an error interrupt.
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0300_0000,
    parameter logic [ADDR_W-1:0] BASE_MASK = 32'hFF00_0000,
    parameter int unsigned       TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic              clock_main,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_wstrb,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic              wbm_stb_o,
    output logic              wbm_cyc_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_status,
    output logic [ADDR_W-1:0] err_addr,
    output logic              irq_err
);

    state_e            state_q, state_d;
    wb_req_t           req_q, req_d;
    logic              cyc_q, cyc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [ERR_W-1:0]  err_status_q, err_status_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              irq_err_q, irq_err_d;

    logic              hit_c;
    logic              timer_clr_c;
    logic              timer_en_c;
    logic              timer_expired_c;
    logic [ERR_W-1:0]  new_err_c;

    // The request that was just answered is still on the bus while mem_ready
    // is high, so it must not be taken as a fresh hit.
    assign hit_c = mem_valid && ((mem_addr & BASE_MASK) == BASE_ADDR) && !mem_ready_q;

    assign timer_en_c = (state_q == CYCLE);

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock_main (clock_main),
        .rst_n      (rst_n),
        .clr        (timer_clr_c),
        .en         (timer_en_c),
        .expired    (timer_expired_c)
    );

    // Next-state, request latch, completion and error-status logic.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cyc_d        = cyc_q;
        rdata_d      = rdata_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = '0;
        err_status_d = err_status_q;
        err_addr_d   = err_addr_q;
        timer_clr_c  = 1'b0;
        new_err_c    = '0;

        if (err_clr) begin
            err_status_d = '0;
            err_addr_d   = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (hit_c) begin
                    req_d.adr   = mem_addr;
                    req_d.dat   = mem_wdata;
                    req_d.we    = |mem_wstrb;
                    req_d.sel   = (|mem_wstrb) ? mem_wstrb : SEL_W'(4'hF);
                    cyc_d       = 1'b1;
                    timer_clr_c = 1'b1;
                    state_d     = CYCLE;
                end else begin
                    cyc_d    = 1'b0;
                    req_d.we = 1'b0;
                end
            end
            CYCLE: begin
                // Priority: ack, then err, then watchdog.
                if (wbm_ack_i) begin
                    rdata_d  = req_q.we ? '0 : wbm_dat_i;
                    cyc_d    = 1'b0;
                    req_d.we = 1'b0;
                    state_d  = DONE;
                end else if (wbm_err_i) begin
                    rdata_d            = ERR_DATA;
                    new_err_c[ERR_BUS] = 1'b1;
                    cyc_d              = 1'b0;
                    req_d.we           = 1'b0;
                    state_d            = DONE;
                end else if (timer_expired_c) begin
                    rdata_d           = ERR_DATA;
                    new_err_c[ERR_TO] = 1'b1;
                    cyc_d             = 1'b0;
                    req_d.we          = 1'b0;
                    state_d           = DONE;
                end
            end
            DONE: begin
                mem_ready_d = 1'b1;
                mem_rdata_d = rdata_q;
                state_d     = IDLE;
            end
            default: begin
                cyc_d    = 1'b0;
                req_d.we = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // A new error overrides a same-cycle clear; only the first error
        // since the last clear records its address.
        if (|new_err_c) begin
            err_status_d = err_status_d | new_err_c;
            if (err_clr || (err_status_q == '0)) begin
                err_addr_d = req_q.adr;
            end
        end

        irq_err_d = |err_status_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock_main) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            cyc_q        <= 1'b0;
            rdata_q      <= '0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= '0;
            err_status_q <= '0;
            err_addr_q   <= '0;
            irq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cyc_q        <= cyc_d;
            rdata_q      <= rdata_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            err_status_q <= err_status_d;
            err_addr_q   <= err_addr_d;
            irq_err_q    <= irq_err_d;
        end
    end

    assign mem_ready  = mem_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign wbm_adr_o  = req_q.adr;
    assign wbm_dat_o  = req_q.dat;
    assign wbm_we_o   = req_q.we;
    assign wbm_sel_o  = req_q.sel;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign err_status = err_status_q;
    assign err_addr   = err_addr_q;
    assign irq_err    = irq_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with a scripted Wishbone slave and a
// read-data scoreboard.
module tb_wb_master_bridge;

    logic        clock_main = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        err_clr;
    logic [1:0]  err_status;
    logic [31:0] err_addr;
    logic        irq_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    // Slave script: 0 silent, 1 ack, 2 err, 3 ack+err; answers resp_delay
    // clocks after stb is first seen.
    int          resp_mode  = 0;
    int          resp_delay = 0;
    logic [31:0] resp_data  = '0;
    int          stb_cnt    = 0;

    always #5 clock_main = ~clock_main;

    wb_master_bridge #(
        .BASE_ADDR (32'h0300_0000),
        .BASE_MASK (32'hFF00_0000),
        .TIMEOUT   (8),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clock_main (clock_main),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .err_clr    (err_clr),
        .err_status (err_status),
        .err_addr   (err_addr),
        .irq_err    (irq_err)
    );

    // Scripted Wishbone slave, driven on the inactive edge.
    always @(negedge clock_main) begin
        if (wbm_cyc_o && wbm_stb_o) begin
            if (stb_cnt == resp_delay) begin
                wbm_ack_i = (resp_mode == 1) || (resp_mode == 3);
                wbm_err_i = (resp_mode == 2) || (resp_mode == 3);
                wbm_dat_i = resp_data;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end
            stb_cnt++;
        end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = '0;
            stb_cnt   = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
    endtask

    // Wait (bounded) for mem_ready, release the request, score the read data.
    task automatic wait_ready(input string tag, input int max_cyc, output int lat);
        logic [31:0] exp;
        lat = 0;
        while ((mem_ready !== 1'b1) && (lat < max_cyc)) begin
            @(negedge clock_main);
            lat++;
        end
        n_checks++;
        assert (mem_ready === 1'b1) n_pass++;
        else $error("FAIL %s_ready observed=%b expected=1", tag, mem_ready);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_rdata"}, mem_rdata, exp);
        end else begin
            n_checks++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int lat;
        int cnt;
        int bad;

        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        err_clr   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock_main);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_err_status", 32'(err_status), 32'd0);
        chk("rst_irq", 32'(irq_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clock_main);

        // Byte-strobed write, ack two clocks after stb.
        resp_mode = 1; resp_delay = 2; resp_data = 32'hFFFF_FFFF;
        issue(32'h0300_0010, 32'h1234_5678, 4'h3);
        exp_q.push_back(32'h0);
        @(negedge clock_main);
        chk("wr_cyc", 32'(wbm_cyc_o), 32'd1);
        chk("wr_stb", 32'(wbm_stb_o), 32'd1);
        chk("wr_we", 32'(wbm_we_o), 32'd1);
        chk("wr_sel", 32'(wbm_sel_o), 32'h3);
        chk("wr_adr", wbm_adr_o, 32'h0300_0010);
        chk("wr_dat", wbm_dat_o, 32'h1234_5678);
        wait_ready("wr", 12, lat);
        @(negedge clock_main);
        chk("wr_pulse_end", 32'(mem_ready), 32'd0);
        chk("wr_rdata_idle", mem_rdata, 32'h0);
        chk("wr_err_status", 32'(err_status), 32'd0);

        // Read with ack on the first CYCLE clock: 3-clock latency.
        resp_mode = 1; resp_delay = 0; resp_data = 32'hCAFE_F00D;
        issue(32'h0300_0004, 32'h0, 4'h0);
        exp_q.push_back(32'hCAFE_F00D);
        @(negedge clock_main);
        chk("rd_sel", 32'(wbm_sel_o), 32'hF);
        chk("rd_we", 32'(wbm_we_o), 32'd0);
        wait_ready("rd", 12, lat);
        chk("rd_latency", 32'(lat + 1), 32'd3);
        @(negedge clock_main);

        // Bus error on the third cycle, then clear.
        resp_mode = 2; resp_delay = 2; resp_data = 32'h1111_2222;
        issue(32'h0300_0020, 32'h0, 4'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        wait_ready("err", 12, lat);
        chk("err_status_bus", 32'(err_status), 32'd1);
        chk("err_addr_bus", err_addr, 32'h0300_0020);
        chk("err_irq", 32'(irq_err), 32'd1);
        @(negedge clock_main);
        err_clr = 1'b1;
        @(negedge clock_main);
        err_clr = 1'b0;
        chk("clr_status", 32'(err_status), 32'd0);
        chk("clr_addr", err_addr, 32'h0);
        chk("clr_irq", 32'(irq_err), 32'd0);

        // Silent slave: watchdog ends the cycle after 8 clocks.
        resp_mode = 0;
        issue(32'h0300_0030, 32'h0, 4'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clock_main);
        cnt = 0;
        while ((wbm_cyc_o === 1'b1) && (cnt < 40)) begin
            cnt++;
            @(negedge clock_main);
        end
        chk("to_cycles", 32'(cnt), 32'd8);
        wait_ready("to", 6, lat);
        chk("to_status", 32'(err_status), 32'h2);
        chk("to_addr", err_addr, 32'h0300_0030);
        chk("to_irq", 32'(irq_err), 32'd1);

        // A second failure keeps the first address.
        @(negedge clock_main);
        resp_mode = 2; resp_delay = 0;
        issue(32'h0300_0040, 32'h0, 4'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        wait_ready("err2", 12, lat);
        chk("err2_status", 32'(err_status), 32'h3);
        chk("err2_addr_kept", err_addr, 32'h0300_0030);
        @(negedge clock_main);
        err_clr = 1'b1;
        @(negedge clock_main);
        err_clr = 1'b0;
        chk("clr2_status", 32'(err_status), 32'd0);

        // Outside the window: no bus activity, no completion.
        resp_mode = 1; resp_delay = 0;
        issue(32'h0200_0000, 32'h0, 4'h0);
        bad = 0;
        repeat (6) begin
            @(negedge clock_main);
            if (wbm_cyc_o || wbm_stb_o || mem_ready) bad++;
        end
        chk("miss_activity", 32'(bad), 32'd0);
        mem_valid = 1'b0;
        @(negedge clock_main);

        // Ack and err together: ack wins, no flag.
        resp_mode = 3; resp_delay = 1; resp_data = 32'h5555_AAAA;
        issue(32'h0300_0050, 32'h0, 4'h0);
        exp_q.push_back(32'h5555_AAAA);
        wait_ready("both", 12, lat);
        chk("both_status", 32'(err_status), 32'd0);
        @(negedge clock_main);

        // Reset in the middle of a cycle.
        resp_mode = 0;
        issue(32'h0300_0060, 32'h0, 4'h0);
        @(negedge clock_main);
        @(negedge clock_main);
        chk("rstmid_pre_cyc", 32'(wbm_cyc_o), 32'd1);
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        @(negedge clock_main);
        chk("rstmid_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rstmid_stb", 32'(wbm_stb_o), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        if (mem_ready) bad++;
        repeat (4) begin
            @(negedge clock_main);
            if (mem_ready) bad++;
        end
        chk("rstmid_no_ready", 32'(bad), 32'd0);

        // Normal read after the reset.
        resp_mode = 1; resp_delay = 1; resp_data = 32'h3C3C_A5A5;
        issue(32'h0300_0070, 32'h0, 4'h0);
        exp_q.push_back(32'h3C3C_A5A5);
        wait_ready("post_rst", 12, lat);
        chk("post_rst_status", 32'(err_status), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Parametrised successor to the SoC's inline picorv32-to-Wishbone glue; converts one native picorv32 memory request inside a configurable address window into one Wishbone classic cycle.
- Adds a watchdog timeout, wbm_err_i handling, sticky error status with capture address, and an error interrupt line for the CPU irq vector.
- Sits between the picorv32 mem_* bus and external Wishbone peripherals; its mem_ready/mem_rdata are OR/mux-ed into the top-level selectors.

Parameters:
- BASE_ADDR, 32'h0300_0000, window base; selection is (mem_addr & BASE_MASK) == BASE_ADDR.
- BASE_MASK, 32'hFF00_0000, window decode mask.
- TIMEOUT, 255, cycles in CYCLE before forced completion; 0 disables the timer.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error or timeout.

Ports:
- clock_main  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- mem_valid  in  1  picorv32 request valid.
- mem_addr  in  32  request address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1, otherwise 0.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- err_clr  in  1  pulse; clears err_status and err_addr.
- err_status  out  2  sticky flags: {timeout, bus_err}.
- err_addr  out  32  address of the first failing cycle since the last clear.
- irq_err  out  1  level output, equal to |err_status.

Behaviour:
- Reset
  - All outputs are 0 and state is IDLE.
  - Reset during CYCLE drops cyc/stb on the next edge.
  - No mem_ready is issued for the aborted request.
- Request select: hit = mem_valid && ((mem_addr & BASE_MASK) == BASE_ADDR). Requests outside the window are ignored entirely.
- IDLE
  - On hit: register adr, dat, we=|mem_wstrb, sel = we ? mem_wstrb : 4'hF. Set cyc=stb=1, clear the timer, go to CYCLE.
  - Otherwise: cyc=stb=we=0.
- CYCLE
  - Outputs are held stable. The timer increments each cycle.
  - wbm_ack_i=1: capture wbm_dat_i (reads only; writes return 0). Clear cyc/stb/we, go to DONE.
  - wbm_err_i=1 and no ack: rdata=ERR_DATA, set bus_err. Clear cyc/stb/we, go to DONE.
  - TIMEOUT!=0, timer==TIMEOUT-1, and neither ack nor err: rdata=ERR_DATA, set timeout. Clear cyc/stb/we, go to DONE.
  - Simultaneous events resolve as ack > err > timeout.
  - If err_status was 0 before this error, err_addr latches wbm_adr_o. Later errors do not overwrite it.
- DONE
  - mem_ready=1 for exactly one cycle with mem_rdata driven.
  - Next state is IDLE. A new hit is accepted in IDLE on the following cycle at the earliest.
- Latency: best case (ack on the first CYCLE clock) is 3 clocks from mem_valid to mem_ready.
- Timeout: a cycle with no response completes TIMEOUT clocks after entering CYCLE.
- mem_valid deasserting during CYCLE violates the picorv32 protocol. The bridge still completes the Wishbone cycle and still pulses mem_ready.
- err_clr
  - Clears err_status and err_addr on the next edge.
  - If a new error is flagged in the same cycle, the new error wins: flags are set and the address is latched.
- Timer width is $clog2(TIMEOUT+1), minimum 1. The timer saturates and never wraps.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'b00, CYCLE=2'b01, DONE=2'b10;
  - default ERR_DATA;
  - status bit indices ERR_BUS=0, ERR_TO=1.
- One sub-module, wb_timeout_counter (params TIMEOUT; ports clock_main, rst_n, clr, en, expired). It holds the saturating counter; expired is tied to 0 when TIMEOUT==0.

Test Plan:
- Write 32'h1234_5678 to 32'h0300_0010, wstrb=4'h3, ack 2 clocks after stb -> wbm_sel_o=4'h3, wbm_we_o=1 during the cycle; one mem_ready pulse; err_status=0.
- Read 32'h0300_0004, slave returns 32'hCAFE_F00D with ack on the first cycle -> mem_rdata=32'hCAFE_F00D on the mem_ready clock; sel=4'hF; latency 3 clocks.
- Read with wbm_err_i at cycle 3 -> mem_rdata=32'hDEAD_BEEF; err_status=2'b01; err_addr=request address; irq_err=1. Then pulse err_clr -> all three return to 0.
- TIMEOUT=8 and slave never responds -> cyc drops 8 clocks after entering CYCLE; mem_rdata=ERR_DATA; err_status=2'b10. A second failing address does not change err_addr.
- Access 32'h0200_0000 (outside the window) -> no cyc/stb and no mem_ready. Ack and err asserted together -> ack data returned, no error flag.
- Assert rst_n=0 mid-CYCLE -> cyc/stb=0 on the next edge, no mem_ready. After reset, a new read completes normally.
